mac_col_n: RTL

MAC_COL_N -- requirements
Module: mac_col_n

---
 rtl/mac_col_n_pkg.sv | 7 +
 rtl/mac_col_n_if.sv | 35 +++
 rtl/mac_col_n_pe.sv | 63 ++++++
 rtl/mac_col_n.sv | 84 ++++++++
 4 files changed

// File: rtl/mac_col_n_pkg.sv
// mac_col_n_pkg: shared FSM state type and default column geometry.
package mac_col_n_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_e;
    localparam int ROWS_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int AW_DEF   = 16;
endpackage

// File: rtl/mac_col_n_if.sv
// mac_col_n_if: weight-load, activation and partial-sum bundle of one MAC column.
// Ports: weight handshake (w_load_i, w_valid_i, w_i, w_ready_o, load_done_o),
// activation handshake (x_valid_i, x_i, x_ready_o), stall_i, row_mask_i, psum_i,
// psum_o, psum_valid_o, chained activation (x_o, x_valid_o) and state_o.
// slave = column side, master = driver side.
interface mac_col_n_if #(
    parameter int ROWS = mac_col_n_pkg::ROWS_DEF,
    parameter int DW   = mac_col_n_pkg::DW_DEF,
    parameter int AW   = mac_col_n_pkg::AW_DEF
);
    logic                 w_load_i;
    logic                 w_valid_i;
    logic [DW-1:0]        w_i;
    logic                 w_ready_o;
    logic                 load_done_o;
    logic                 x_valid_i;
    logic [DW-1:0]        x_i;
    logic                 x_ready_o;
    logic                 stall_i;
    logic [ROWS-1:0]      row_mask_i;
    logic [ROWS*AW-1:0]   psum_i;
    logic [ROWS*AW-1:0]   psum_o;
    logic [ROWS-1:0]      psum_valid_o;
    logic [DW-1:0]        x_o;
    logic                 x_valid_o;
    logic [1:0]           state_o;
    modport slave (
        input  w_load_i, w_valid_i, w_i, x_valid_i, x_i, stall_i, row_mask_i, psum_i,
        output w_ready_o, load_done_o, x_ready_o, psum_o, psum_valid_o, x_o, x_valid_o, state_o
    );
    modport master (
        output w_load_i, w_valid_i, w_i, x_valid_i, x_i, stall_i, row_mask_i, psum_i,
        input  w_ready_o, load_done_o, x_ready_o, psum_o, psum_valid_o, x_o, x_valid_o, state_o
    );
endinterface

// File: rtl/mac_col_n_pe.sv
// mac_pe: one processing element of the column (weight, x, psum and valid registers).
// Ports: clk, rst, en (0 freezes all registers), w_sh/w_in/w_o (weight shift chain),
// x_in/xv_in (activation used this cycle), mask (1 = MAC, 0 = bypass psum_in),
// psum_in, x_o/v_o (registered activation and valid), psum_o (registered sum).
// Build option: MAC_COL_SAT_EN saturates the sum, otherwise it wraps modulo 2^AW.
module mac_pe #(
    parameter int DW = mac_col_n_pkg::DW_DEF,
    parameter int AW = mac_col_n_pkg::AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 w_sh,
    input  logic signed [DW-1:0] w_in,
    output logic signed [DW-1:0] w_o,
    input  logic signed [DW-1:0] x_in,
    input  logic                 xv_in,
    input  logic                 mask,
    input  logic signed [AW-1:0] psum_in,
    output logic signed [DW-1:0] x_o,
    output logic                 v_o,
    output logic signed [AW-1:0] psum_o
);
    logic signed [DW-1:0]   w_q, w_d, x_q, x_d;
    logic                   v_q, v_d;
    logic signed [AW-1:0]   psum_q, psum_d, mac;
    logic signed [2*DW-1:0] prod;
`ifdef MAC_COL_SAT_EN
    logic signed [AW:0]     sum;
`endif
    always_comb begin
        prod = (2*DW)'(x_in) * (2*DW)'(w_q);
`ifdef MAC_COL_SAT_EN
        // One guard bit detects overflow; clamp toward the sign of the true result.
        sum = (AW+1)'(psum_in) + (AW+1)'(prod);
        mac = (sum[AW] != sum[AW-1]) ? (sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})
                                     : sum[AW-1:0];
`else
        mac = psum_in + AW'(prod);
`endif
        w_d    = (en && w_sh) ? w_in : w_q;
        x_d    = en ? x_in : x_q;
        v_d    = en ? xv_in : v_q;
        psum_d = (en && xv_in) ? (mask ? mac : psum_in) : psum_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q    <= '0;
            x_q    <= '0;
            v_q    <= 1'b0;
            psum_q <= '0;
        end else begin
            w_q    <= w_d;
            x_q    <= x_d;
            v_q    <= v_d;
            psum_q <= psum_d;
        end
    end
    assign w_o    = w_q;
    assign x_o    = x_q;
    assign v_o    = v_q;
    assign psum_o = psum_q;
endmodule

// File: rtl/mac_col_n.sv
// mac_col_n: weight-stationary MAC column of ROWS PEs with load/run/drain control.
// Ports: clk, rst (sync, active high), bus (mac_col_n_if.slave) carrying the weight
// and activation handshakes, stall, row mask, partial sums in/out and state.
// Build option: MAC_COL_SAT_EN selects saturating sums inside each PE.
module mac_col_n
    import mac_col_n_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input logic        clk,
    input logic        rst,
    mac_col_n_if.slave bus
);
    localparam int LCW = $clog2(ROWS);
    localparam int CCW = $clog2(ROWS + 1);
    state_e               state_q, state_d;
    logic [LCW-1:0]       ld_q, ld_d;
    logic [CCW-1:0]       cnt_q, cnt_d;
    logic                 stall, w_rdy, w_acc, x_rdy, x_acc, ret, done;
    logic signed [DW-1:0] w_c [ROWS+1];
    logic signed [DW-1:0] x_c [ROWS+1];
    logic [ROWS:0]        v_c;
    logic signed [AW-1:0] p_c [ROWS];
    assign w_c[0] = bus.w_i;
    assign x_c[0] = bus.x_i;
    assign v_c[0] = x_acc;
    always_comb begin
        stall = bus.stall_i;
        w_rdy = state_q == LOAD && !stall;
        w_acc = w_rdy && bus.w_valid_i;
        done  = w_acc && ld_q == LCW'(ROWS - 1);
        x_rdy = state_q == RUN && !stall && !bus.w_load_i;
        x_acc = x_rdy && bus.x_valid_i;
        // An activation retires in the cycle the bottom row consumes it.
        ret   = v_c[ROWS-1] && !stall;
        cnt_d = cnt_q + CCW'(x_acc) - CCW'(ret);
        state_d = stall                                 ? state_q :
                  (state_q == IDLE  && bus.w_load_i)    ? LOAD :
                  (state_q == LOAD  && done)            ? RUN :
                  (state_q == RUN   && bus.w_load_i)    ? (cnt_d == '0 ? LOAD : DRAIN) :
                  (state_q == DRAIN && cnt_d == '0)     ? LOAD : state_q;
        ld_d  = (state_d == LOAD && state_q != LOAD) ? '0 :
                done                                 ? '0 :
                w_acc                                ? ld_q + LCW'(1) : ld_q;
        bus.w_ready_o   = w_rdy;
        bus.load_done_o = done;
        bus.x_ready_o   = x_rdy;
        bus.x_o         = x_c[ROWS];
        bus.x_valid_o   = v_c[ROWS];
        bus.state_o     = state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ld_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        mac_pe #(.DW(DW), .AW(AW)) u_pe (
            .clk     (clk),
            .rst     (rst),
            .en      (!stall),
            .w_sh    (w_acc),
            .w_in    (w_c[r]),
            .w_o     (w_c[r+1]),
            .x_in    (x_c[r]),
            .xv_in   (v_c[r]),
            .mask    (bus.row_mask_i[r]),
            .psum_in (bus.psum_i[r*AW +: AW]),
            .x_o     (x_c[r+1]),
            .v_o     (v_c[r+1]),
            .psum_o  (p_c[r])
        );
        assign bus.psum_o[r*AW +: AW] = p_c[r];
        assign bus.psum_valid_o[r]    = v_c[r+1];
    end
endmodule
